// File: rtl/fifo_access_arbiter.sv
// fifo_access_arbiter
//   Access controller for a small FIFO. It arbitrates write access between
//   two producers with round-robin fairness and gates a single consumer's
//   reads. Its push/pop strobes never write a full FIFO and never read an
//   empty one. It keeps a shadow occupancy count, flags any disagreement
//   with the FIFO's status flags, and runs a flush sequence that drains the
//   FIFO.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_req_wr[1:0]           write requests, bit i from producer i
//   i_wr_data0/1            producer data
//   o_grant_wr[1:0]         one-hot write grant (combinational)
//   o_fifo_wr_data          data from the granted producer, 0 when idle
//   o_in_write_ctrl         FIFO push strobe
//   i_rd_req                consumer read request
//   o_rd_grant              consumer read accepted this cycle
//   o_in_read_ctrl          FIFO pop strobe
//   i_out_is_empty/full     FIFO status flags
//   i_flush                 single-cycle flush request
//   o_flush_busy            high while draining
//   o_flush_done            one-cycle pulse after a drain completes
//   o_occupancy             shadow entry count
//   o_err_mismatch          sticky flag-consistency error
module fifo_access_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_req_wr,
  input  logic [WIDTH-1:0] i_wr_data0,
  input  logic [WIDTH-1:0] i_wr_data1,
  output logic [1:0]       o_grant_wr,
  output logic [WIDTH-1:0] o_fifo_wr_data,
  output logic             o_in_write_ctrl,
  input  logic             i_rd_req,
  output logic             o_rd_grant,
  output logic             o_in_read_ctrl,
  input  logic             i_out_is_empty,
  input  logic             i_out_is_full,
  input  logic             i_flush,
  output logic             o_flush_busy,
  output logic             o_flush_done,
  output logic [CW-1:0]    o_occupancy,
  output logic             o_err_mismatch
);

  localparam logic [0:0]    ST_RUN     = 1'b0;
  localparam logic [0:0]    ST_DRAIN   = 1'b1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [0:0]       r_state;
  logic             r_last;
  logic [CW-1:0]    r_occupancy;
  logic             r_err;
  logic             r_flush_done;

  logic             w_run;
  logic [1:0]       w_grant;
  logic [WIDTH-1:0] w_data;
  logic             w_push;
  logic             w_pop;
  logic             w_drain_exit;
  logic             w_mismatch;

  // Strobes are forced low combinationally while reset is asserted.
  assign w_run = (r_state == ST_RUN) && !i_rst;

  // Round-robin: on a tie the producer not granted most recently wins.
  // r_last holds the index of the last winner.
  always_comb begin
    w_grant = 2'b00;
    if (w_run && !i_out_is_full) begin
      case (i_req_wr)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    case (w_grant)
      2'b01:   w_data = i_wr_data0;
      2'b10:   w_data = i_wr_data1;
      default: w_data = '0;
    endcase
  end

  assign w_push = |w_grant;

  // In DRAIN every non-empty cycle pops. The consumer never sees that data.
  assign w_pop = !i_rst && !i_out_is_empty && ((r_state == ST_DRAIN) || i_rd_req);

  // Leave DRAIN only once the shadow count is zero and nothing is popping.
  assign w_drain_exit = (r_state == ST_DRAIN) && (r_occupancy == '0) && !w_pop;

  assign w_mismatch = ((r_occupancy == '0) != i_out_is_empty) ||
                      ((r_occupancy == FULL_COUNT) != i_out_is_full);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_RUN;
      r_last       <= 1'b1;
      r_occupancy  <= '0;
      r_err        <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      if (r_state == ST_RUN && i_flush)
        r_state <= ST_DRAIN;
      else if (w_drain_exit)
        r_state <= ST_RUN;

      if (w_push)
        r_last <= w_grant[1];

      // A simultaneous push and pop leaves the count unchanged.
      if (w_push && !w_pop)
        r_occupancy <= r_occupancy + CW'(1);
      else if (w_pop && !w_push)
        r_occupancy <= r_occupancy - CW'(1);

      r_flush_done <= w_drain_exit;

      if (w_mismatch)
        r_err <= 1'b1;
    end
  end

  assign o_grant_wr      = w_grant;
  assign o_fifo_wr_data  = w_data;
  assign o_in_write_ctrl = w_push;
  assign o_rd_grant      = w_run && i_rd_req && !i_out_is_empty;
  assign o_in_read_ctrl  = w_pop;
  assign o_flush_busy    = (r_state == ST_DRAIN);
  assign o_flush_done    = r_flush_done;
  assign o_occupancy     = r_occupancy;
  assign o_err_mismatch  = r_err;

endmodule
